// File: rtl/half_duplex_line_ctrl_if.sv
// Host-side and pad-side signals of the half-duplex line sequencer,
// bundled so the host, the pad model and the controller share one port.
interface half_duplex_line_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              rd_en;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              t;
  logic              o_drv;
  logic              i_pad;

  modport master (
    output start, rd_en, wr_data, i_pad,
    input  busy, done, rd_valid, rd_data, t, o_drv
  );

  modport slave (
    input  start, rd_en, wr_data, i_pad,
    output busy, done, rd_valid, rd_data, t, o_drv
  );
endinterface

// File: rtl/half_duplex_line_ctrl.sv
// Half-duplex single-pin sequencer: shift a word out, release the line,
// optionally shift a reply in through a 2-flop synchronizer.
module half_duplex_line_ctrl #(
  parameter int DATA_W   = 8,
  parameter int BIT_CYC  = 4,
  parameter int TURN_CYC = 2
) (
  input logic clk,
  input logic rst,
  half_duplex_line_ctrl_if.slave bus
);
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, TX, TURN, RX, DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] shift, shift_n;
  logic [DATA_W-1:0] rx_shift, rx_n;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W:0]   tx_ext, rx_ext;
  logic [CW-1:0]     cyc_cnt, cyc_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [TW-1:0]     turn_cnt, turn_n;
  logic              rd_lat, lat_n;
  logic              s1, s2;
  logic              cell_end, last_bit;
  logic              t_q, o_q, busy_q, done_q, rv_q;
  logic              t_n, o_n, busy_n, done_n, rv_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      rx_shift <= '0;
      rd_q     <= '0;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      turn_cnt <= '0;
      rd_lat   <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      t_q      <= 1'b0;
      o_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      rx_shift <= rx_n;
      cyc_cnt  <= cyc_n;
      bit_cnt  <= bit_n;
      turn_cnt <= turn_n;
      rd_lat   <= lat_n;
      s1       <= bus.i_pad;
      s2       <= s1;
      t_q      <= t_n;
      o_q      <= o_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      rv_q     <= rv_n;
      if (rv_n) rd_q <= rx_n;
    end
  end

  // Extended vectors keep the shifts legal even when DATA_W is 1.
  assign tx_ext   = {shift, 1'b0};
  assign rx_ext   = {rx_shift, s2};
  assign cell_end = (cyc_cnt == CW'(BIT_CYC - 1));
  assign last_bit = (bit_cnt == BW'(DATA_W - 1));

  always_comb begin
    state_n = state;
    shift_n = shift;
    rx_n    = rx_shift;
    lat_n   = rd_lat;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    turn_n  = turn_cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          shift_n = bus.wr_data;
          lat_n   = bus.rd_en;
          cyc_n   = '0;
          bit_n   = '0;
          turn_n  = '0;
          state_n = TX;
        end
      end
      TX: begin
        if (cell_end) begin
          cyc_n   = '0;
          shift_n = tx_ext[DATA_W-1:0];
          if (last_bit) begin
            bit_n   = '0;
            state_n = TURN;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == TW'(TURN_CYC - 1)) begin
          turn_n  = '0;
          state_n = rd_lat ? RX : DONE;
        end else begin
          turn_n = turn_cnt + 1'b1;
        end
      end
      RX: begin
        if (cell_end) begin
          cyc_n = '0;
          rx_n  = rx_ext[DATA_W-1:0];
          if (last_bit) begin
            bit_n   = '0;
            state_n = DONE;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pad outputs are flops fed from the next state so they never glitch.
  always_comb begin
    t_n    = (state_n == TX);
    o_n    = t_n & shift_n[DATA_W-1];
    busy_n = (state_n == TX) || (state_n == TURN) || (state_n == RX);
    done_n = (state_n == DONE);
    rv_n   = done_n & lat_n;
  end

  assign bus.t        = t_q;
  assign bus.o_drv    = o_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rv_q;
  assign bus.rd_data  = rd_q;
endmodule

// File: tb/tb_half_duplex_line_ctrl.sv
// Directed bench for half_duplex_line_ctrl: default build plus a
// minimal DATA_W=1 / BIT_CYC=2 / TURN_CYC=1 build on the same clock.
module tb_half_duplex_line_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  half_duplex_line_ctrl_if #(.DATA_W(8)) bus ();
  half_duplex_line_ctrl_if #(.DATA_W(1)) bus1 ();

  half_duplex_line_ctrl #(
    .DATA_W(8), .BIT_CYC(4), .TURN_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  half_duplex_line_ctrl #(
    .DATA_W(1), .BIT_CYC(2), .TURN_CYC(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.start    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.wr_data  = '0;
    bus.i_pad    = 1'b0;
    bus1.start   = 1'b0;
    bus1.rd_en   = 1'b0;
    bus1.wr_data = '0;
    bus1.i_pad   = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.t !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset c%0d: t=%b busy=%b done=%b rd=%h want 0",
                 c, bus.t, bus.busy, bus.done, bus.rd_data);
      end
    end
    checks++;
    if (bus1.t !== 1'b0 || bus1.busy !== 1'b0 || bus1.rd_data !== 1'b0) begin
      errors++;
      $display("FAIL reset_w1: t=%b busy=%b rd=%b want 0",
               bus1.t, bus1.busy, bus1.rd_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.t !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle: t=%b busy=%b done=%b want 0",
               bus.t, bus.busy, bus.done);
    end
  endtask

  task automatic test_write_only(input logic [7:0] w, input logic [7:0] keep);
    logic exp;
    bus.wr_data = w;
    bus.rd_en   = 1'b0;
    bus.i_pad   = 1'b0;
    bus.start   = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      bus.start = 1'b0;
      checks++;
      if (c <= 32) begin
        exp = w[7-(c-1)/4];
        if (bus.t !== 1'b1 || bus.o_drv !== exp || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL wr_tx c%0d: t=%b o=%b busy=%b want 1 %b 1",
                   c, bus.t, bus.o_drv, bus.busy, exp);
        end
      end else if (c <= 34) begin
        if (bus.t !== 1'b0 || bus.o_drv !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL wr_turn c%0d: t=%b o=%b busy=%b want 0 0 1",
                   c, bus.t, bus.o_drv, bus.busy);
        end
      end else if (c == 35) begin
        if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.t !== 1'b0 || bus.rd_data !== keep) begin
          errors++;
          $display("FAIL wr_done: done=%b rv=%b busy=%b t=%b rd=%h want 1 0 0 0 %h",
                   bus.done, bus.rd_valid, bus.busy, bus.t, bus.rd_data, keep);
        end
      end else begin
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL wr_after: busy=%b done=%b want 0 0",
                   bus.busy, bus.done);
        end
      end
    end
  endtask

  task automatic test_write_read;
    logic [7:0] w;
    logic [7:0] rx;
    logic       exp;
    w  = 8'h3C;
    rx = 8'hC3;
    bus.wr_data = w;
    bus.rd_en   = 1'b1;
    bus.i_pad   = 1'b0;
    bus.start   = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      bus.start = 1'b0;
      if (c >= 35 && c <= 66) bus.i_pad = rx[7-(c-35)/4];
      else bus.i_pad = 1'b0;
      checks++;
      if (c <= 32) begin
        exp = w[7-(c-1)/4];
        if (bus.t !== 1'b1 || bus.o_drv !== exp) begin
          errors++;
          $display("FAIL wrrd_tx c%0d: t=%b o=%b want 1 %b",
                   c, bus.t, bus.o_drv, exp);
        end
      end else if (c <= 66) begin
        if (bus.t !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL wrrd_mid c%0d: t=%b busy=%b done=%b want 0 1 0",
                   c, bus.t, bus.busy, bus.done);
        end
      end else if (c == 67) begin
        if (bus.done !== 1'b1 || bus.rd_valid !== 1'b1 ||
            bus.rd_data !== 8'hC3 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL wrrd_done: done=%b rv=%b rd=%h busy=%b want 1 1 c3 0",
                   bus.done, bus.rd_valid, bus.rd_data, bus.busy);
        end
      end else begin
        if (bus.rd_data !== 8'hC3 || bus.done !== 1'b0 ||
            bus.rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL wrrd_hold c%0d: rd=%h done=%b rv=%b want c3 0 0",
                   c, bus.rd_data, bus.done, bus.rd_valid);
        end
      end
    end
  endtask

  task automatic test_start_busy;
    int dones;
    dones = 0;
    bus.wr_data = 8'hFF;
    bus.rd_en   = 1'b1;
    bus.i_pad   = 1'b1;
    bus.start   = 1'b1;
    for (int c = 1; c <= 68; c++) begin
      tick();
      bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
      if (c == 5) begin
        bus.start   = 1'b1;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
      end
      if (c == 9) begin
        checks++;
        if (bus.t !== 1'b1 || bus.o_drv !== 1'b1) begin
          errors++;
          $display("FAIL busy_latch: t=%b o=%b want 1 1", bus.t, bus.o_drv);
        end
      end
      if (c == 67) begin
        checks++;
        if (bus.done !== 1'b1 || bus.rd_valid !== 1'b1 ||
            bus.rd_data !== 8'hFF) begin
          errors++;
          $display("FAIL busy_done: done=%b rv=%b rd=%h want 1 1 ff",
                   bus.done, bus.rd_valid, bus.rd_data);
        end
        bus.start = 1'b1;
      end
      if (c == 68) begin
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.t !== 1'b0) begin
          errors++;
          $display("FAIL busy_done_start: done=%b busy=%b t=%b want 0 0 0",
                   bus.done, bus.busy, bus.t);
        end
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d want 1", dones);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.t !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_accept69: t=%b busy=%b want 1 1", bus.t, bus.busy);
    end
    repeat (70) tick();
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    bus.wr_data = 8'hFF;
    bus.rd_en   = 1'b1;
    bus.start   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.t !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_c21: t=%b busy=%b done=%b want 0 0 0",
               bus.t, bus.busy, bus.done);
    end
    for (int c = 22; c <= 80; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.rd_valid === 1'b1 ||
          bus.busy === 1'b1 || bus.t === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: active cycles %0d want 0", dones);
    end
  endtask

  task automatic test_param_min;
    bus1.wr_data = 1'b1;
    bus1.rd_en   = 1'b1;
    bus1.i_pad   = 1'b1;
    bus1.start   = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus1.start = 1'b0;
      checks++;
      if (c <= 2) begin
        if (bus1.t !== 1'b1 || bus1.o_drv !== 1'b1 || bus1.busy !== 1'b1) begin
          errors++;
          $display("FAIL w1_tx c%0d: t=%b o=%b busy=%b want 1 1 1",
                   c, bus1.t, bus1.o_drv, bus1.busy);
        end
      end else if (c <= 5) begin
        if (bus1.t !== 1'b0 || bus1.busy !== 1'b1 ||
            bus1.done !== 1'b0 || bus1.rd_data !== 1'b0) begin
          errors++;
          $display("FAIL w1_mid c%0d: t=%b busy=%b done=%b rd=%b want 0 1 0 0",
                   c, bus1.t, bus1.busy, bus1.done, bus1.rd_data);
        end
      end else if (c == 6) begin
        if (bus1.done !== 1'b1 || bus1.rd_valid !== 1'b1 ||
            bus1.rd_data !== 1'b1 || bus1.busy !== 1'b0) begin
          errors++;
          $display("FAIL w1_done: done=%b rv=%b rd=%b busy=%b want 1 1 1 0",
                   bus1.done, bus1.rd_valid, bus1.rd_data, bus1.busy);
        end
      end else begin
        if (bus1.done !== 1'b0 || bus1.rd_data !== 1'b1) begin
          errors++;
          $display("FAIL w1_after: done=%b rd=%b want 0 1",
                   bus1.done, bus1.rd_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_only(8'hA5, 8'h00);
    test_write_read();
    test_write_only(8'h5A, 8'hC3);
    test_start_busy();
    test_reset_mid();
    test_write_only(8'hA5, 8'h00);
    test_param_min();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/half_duplex_line_ctrl.md
Name: half_duplex_line_ctrl

Overview:
- Transaction sequencer for a single shared bidirectional pin, driving the pin's tristate enable and output value, and reading back the raw pad level.
- Per transaction: shifts out a DATA_W-bit word, releases the line for a turnaround gap, then optionally samples a DATA_W-bit reply.
- The pad input passes through an internal 2-flop synchronizer before sampling.
- Sits between a register or host interface and the bidir pad cell.

Parameters:
- DATA_W, 8, bits per TX word and per RX word; must be >= 1.
- BIT_CYC, 4, clock cycles per bit cell; must be >= 2.
- TURN_CYC, 2, cycles the line is released between TX and RX/DONE; must be >= 1.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transaction request, sampled only in IDLE.
- rd_en  in  1  1 = perform RX phase; latched with start.
- wr_data  in  DATA_W  word to transmit, MSB first; latched with start.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end.
- rd_valid  out  1  one-cycle pulse with done when the latched rd_en=1.
- rd_data  out  DATA_W  received word, MSB first.
- t  out  1  pad drive enable; 1 = drive, 0 = high-Z.
- o_drv  out  1  value driven onto the pad when t=1.
- i_pad  in  1  raw pad level, asynchronous to clk.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, rd_valid=0, rd_data=0, t=0, o_drv=0, sync flops=0, counters=0.
- rst asserted mid-transaction: t=0 and busy=0 from the cycle after the reset edge. No done or rd_valid pulse.
- Synchronizer: i_pad feeds s1, then s2, every clock. Only s2 is used, so it lags the pad by 2 cycles.
- Counters:
  - cyc_cnt runs 0..BIT_CYC-1.
  - bit_cnt runs 0..DATA_W-1.
  - turn_cnt runs 0..TURN_CYC-1.
- IDLE:
  - busy=0, t=0.
  - If start=1: latch wr_data into the shift register, latch rd_en, clear counters, go to TX.
- TX:
  - busy=1, t=1, o_drv=shift MSB.
  - cyc_cnt increments each cycle.
  - At cyc_cnt=BIT_CYC-1: shift left, increment bit_cnt, wrap cyc_cnt to 0.
  - After the last cycle of bit DATA_W-1: go to TURN.
  - Duration is exactly DATA_W*BIT_CYC cycles.
- TURN:
  - busy=1, t=0, o_drv=0.
  - Lasts exactly TURN_CYC cycles.
  - Exit to RX if latched rd_en=1, else to DONE.
- RX:
  - busy=1, t=0.
  - At cyc_cnt=BIT_CYC-1 of each cell: rx_shift = {rx_shift[DATA_W-2:0], s2}.
  - Duration is exactly DATA_W*BIT_CYC cycles, then go to DONE.
- DONE:
  - One cycle: busy=0, done=1, t=0.
  - rd_valid=1 and rd_data<=rx_shift (visible in this cycle) if latched rd_en=1.
  - Then go to IDLE.
- Start handling:
  - start in any state other than IDLE is ignored, including the DONE cycle. It is not queued.
  - wr_data and rd_en changes after acceptance have no effect.
- rd_data holds its value until the next read transaction's DONE. It is unchanged by write-only transactions.
- Timing from the accept edge (cycle 0 = cycle in which start=1 is sampled in IDLE):
  - Write+read: TX cycles 1..DATA_W*BIT_CYC, then TURN_CYC cycles, then RX DATA_W*BIT_CYC cycles, then DONE.
  - Defaults (write+read): TX 1..32, TURN 33..34, RX 35..66, DONE 67.
  - Defaults (write-only): DONE at cycle 35.
- t is never 1 outside TX. t is registered and glitch-free.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, start=0 -> t=0, busy=0, done=0, rd_data=0 throughout.
- Write-only: wr_data=8'hA5, rd_en=0, start pulse at cycle 0 -> o_drv pattern 1,0,1,0,0,1,0,1 with each bit held 4 cycles (cycles 1..32, t=1); t=0 at cycles 33..34; done=1 and rd_valid=0 at cycle 35; busy=0 at cycle 36.
- Write+read: wr_data=8'h3C, rd_en=1. Bench drives i_pad with 8'hC3 MSB-first, with each bit starting at cycle 35+4k (so the level is stable from cycle 35+4k through the cycle-35+4k+3 sample point) -> done=1, rd_valid=1, rd_data=8'hC3 at cycle 67; rd_data holds 8'hC3 afterwards.
- Start while busy: second start pulses at cycles 5 and 67 (DONE) -> ignored, one done only. A start at cycle 68 is accepted, with t=1 at cycle 69.
- Reset mid-op: rst=1 at cycle 20 of a transaction -> t=0 and busy=0 from cycle 21; no done pulse; next start behaves normally.
- Parameter sweep DATA_W=1, BIT_CYC=2, TURN_CYC=1, rd_en=1 -> TX cycles 1..2, TURN cycle 3, RX cycles 4..5 with sample at cycle 5, DONE at cycle 6.
